k16_io_scanner: RTL and testbench

K16_IO_SCANNER -- requirements
Module: k16_io_scanner

---
 rtl/k16_io_scanner.sv | 109 ++++++++++
 tb/tb_k16_io_scanner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/k16_io_scanner.sv
// Time-multiplexed scanner that moves CPU port words over a narrow nibble bus and captures input slices.
// Define K16_IO_SNAPSHOT_EN to stage captures in a shadow word and publish cpuInput once per frame.
module k16_io_scanner #(
   parameter int unsigned PORTS      = 2,
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned BUS_WIDTH  = 4,
   parameter int unsigned DWELL      = 1,
   localparam int unsigned FLAT_WIDTH = PORTS * WORD_WIDTH,
   localparam int unsigned SLOTS      = FLAT_WIDTH / BUS_WIDTH,
   localparam int unsigned SEL_WIDTH  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic [SEL_WIDTH-1:0]  select,
   output logic [BUS_WIDTH-1:0]  outputBits,
   input  logic [BUS_WIDTH-1:0]  inputBits,
   input  logic [FLAT_WIDTH-1:0] cpuOutput,
   output logic [FLAT_WIDTH-1:0] cpuInput,
   output logic                  frameDone
);

   localparam int unsigned DWELL_WIDTH = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                  state;
   logic [DWELL_WIDTH-1:0]  dwell;
   logic                    last_dwell_c;
   logic                    last_slot_c;
   logic [SEL_WIDTH-1:0]    next_sel_c;
   logic [BUS_WIDTH-1:0]    next_slice_c;
   logic [FLAT_WIDTH-1:0]   capture_c;
`ifdef K16_IO_SNAPSHOT_EN
   logic [FLAT_WIDTH-1:0]   shadow;
`endif

   // Slot sequencing plus the captured word as it will look after this slot's capture edge.
   always_comb begin
      last_dwell_c = (dwell == DWELL_WIDTH'(DWELL - 1));
      last_slot_c  = (select == SEL_WIDTH'(SLOTS - 1));
      next_sel_c   = last_slot_c ? '0 : select + 1'b1;
      next_slice_c = '0;
`ifdef K16_IO_SNAPSHOT_EN
      capture_c    = shadow;
`else
      capture_c    = cpuInput;
`endif
      for (int unsigned s = 0; s < SLOTS; s++) begin
         if (next_sel_c == SEL_WIDTH'(s)) begin
            next_slice_c = cpuOutput[s*BUS_WIDTH +: BUS_WIDTH];
         end
         if (select == SEL_WIDTH'(s)) begin
            capture_c[s*BUS_WIDTH +: BUS_WIDTH] = inputBits;
         end
      end
   end

   // IDLE keeps slot 0 presented; SCAN walks slots and only leaves at a frame boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         select     <= '0;
         dwell      <= '0;
         outputBits <= '0;
         cpuInput   <= '0;
         frameDone  <= 1'b0;
`ifdef K16_IO_SNAPSHOT_EN
         shadow     <= '0;
`endif
      end else begin
         frameDone <= 1'b0;
         case (state)
            IDLE: begin
               select     <= '0;
               dwell      <= '0;
               outputBits <= cpuOutput[BUS_WIDTH-1:0];
               if (enable) begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (!last_dwell_c) begin
                  dwell <= dwell + 1'b1;
               end else begin
                  dwell      <= '0;
                  select     <= next_sel_c;
                  outputBits <= next_slice_c;
`ifdef K16_IO_SNAPSHOT_EN
                  shadow <= capture_c;
                  if (last_slot_c) begin
                     cpuInput <= capture_c;
                  end
`else
                  cpuInput <= capture_c;
`endif
                  if (last_slot_c) begin
                     frameDone <= 1'b1;
                     if (!enable) begin
                        state <= IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_k16_io_scanner.sv
// Scoreboard bench: two scanner configurations run in lockstep against a frame-position reference model.
module tb_k16_io_scanner;

   typedef struct {
      bit          busy;
      int          pos;
      int          sel;
      bit          fd;
      logic [63:0] cin;
      logic [63:0] shadow;
      logic [7:0]  ob;
   } mstate_t;

   typedef struct {
      mstate_t a;
      mstate_t b;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [2:0]  sel_a;
   logic [3:0]  ob_a;
   logic [3:0]  ib_a;
   logic [31:0] co_a;
   logic [31:0] ci_a;
   logic        fd_a;
   logic [2:0]  sel_b;
   logic [7:0]  ob_b;
   logic [7:0]  ib_b;
   logic [47:0] co_b;
   logic [47:0] ci_b;
   logic        fd_b;

   int vectors = 0;
   int miscompares = 0;
   exp_t q[$];
   exp_t e_mon;
   mstate_t ma;
   mstate_t mb;

   k16_io_scanner dut_a (
      .clk(clk), .reset(reset), .enable(enable), .select(sel_a), .outputBits(ob_a),
      .inputBits(ib_a), .cpuOutput(co_a), .cpuInput(ci_a), .frameDone(fd_a)
   );

   k16_io_scanner #(.PORTS(3), .WORD_WIDTH(16), .BUS_WIDTH(8), .DWELL(3)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .select(sel_b), .outputBits(ob_b),
      .inputBits(ib_b), .cpuOutput(co_b), .cpuInput(ci_b), .frameDone(fd_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame position counts cycles since slot 0 began; slot = pos / dwell.
   function automatic mstate_t step(mstate_t m, int slots, int dwell, int bw, bit rst, bit en,
                                    logic [63:0] co, logic [7:0] ib);
      mstate_t     n;
      logic [63:0] mask;
      logic [63:0] c;
      int          slot;
      n    = m;
      mask = (64'd1 << bw) - 64'd1;
      n.fd = 1'b0;
      if (rst) begin
         n.busy = 1'b0; n.pos = 0; n.sel = 0; n.cin = '0; n.shadow = '0; n.ob = '0;
      end else if (!m.busy) begin
         n.ob   = 8'(co & mask);
         n.sel  = 0;
         n.pos  = 0;
         n.busy = en;
      end else begin
         n.pos = m.pos + 1;
         if (n.pos % dwell == 0) begin
            slot = m.pos / dwell;
`ifdef K16_IO_SNAPSHOT_EN
            c = m.shadow;
`else
            c = m.cin;
`endif
            c = (c & ~(mask << (slot * bw))) | ((64'(ib) & mask) << (slot * bw));
`ifdef K16_IO_SNAPSHOT_EN
            n.shadow = c;
`else
            n.cin = c;
`endif
            if (n.pos == slots * dwell) begin
               n.pos  = 0;
               n.fd   = 1'b1;
               n.cin  = c;
               n.busy = en;
            end
            n.ob = 8'((co >> ((n.pos / dwell) * bw)) & mask);
         end
         n.sel = n.pos / dwell;
      end
      return n;
   endfunction

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   task automatic drive(bit rst, bit en, logic [63:0] co, logic [7:0] iba, logic [7:0] ibb);
      exp_t e;
      @(negedge clk);
      reset  = rst;
      enable = en;
      co_a   = co[31:0];
      co_b   = co[47:0];
      ib_a   = iba[3:0];
      ib_b   = ibb;
      ma = step(ma, 8, 1, 4, rst, en, {32'b0, co[31:0]}, {4'b0, iba[3:0]});
      mb = step(mb, 6, 3, 8, rst, en, {16'b0, co[47:0]}, ibb);
      e.a = ma;
      e.b = mb;
      q.push_back(e);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Monitor: each clock presents one registered output set, checked against the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e_mon = q.pop_front();
         chk("a_select",   64'(sel_a), 64'(e_mon.a.sel));
         chk("a_outbits",  64'(ob_a),  64'(e_mon.a.ob));
         chk("a_framedone",64'(fd_a),  64'(e_mon.a.fd));
         chk("a_cpuinput", 64'(ci_a),  e_mon.a.cin);
         chk("b_select",   64'(sel_b), 64'(e_mon.b.sel));
         chk("b_outbits",  64'(ob_b),  64'(e_mon.b.ob));
         chk("b_framedone",64'(fd_b),  64'(e_mon.b.fd));
         chk("b_cpuinput", 64'(ci_b),  e_mon.b.cin);
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b0; co_a = '0; co_b = '0; ib_a = '0; ib_b = '0;
      ma = '{busy: 1'b0, pos: 0, sel: 0, fd: 1'b0, cin: '0, shadow: '0, ob: '0};
      mb = ma;

      // Reset with garbage on the inputs must still yield all-zero outputs.
      repeat (3) drive(1'b1, 1'b1, rnd64(), 8'($urandom), 8'($urandom));

      // Fixed pattern, external device answers select+1.
      repeat (40) drive(1'b0, 1'b1, 64'hCAFE_0000_BEEF_1234, 8'(ma.sel + 1), 8'(mb.sel + 1));

      // Drop enable at slot 3: frame must still complete, then idle tracks slot 0.
      for (int i = 0; i < 20 && !(ma.busy && ma.sel == 3); i++)
         drive(1'b0, 1'b1, rnd64(), 8'($urandom), 8'($urandom));
      repeat (30) drive(1'b0, 1'b0, rnd64(), 8'($urandom), 8'($urandom));

      // Reset mid-frame at slot 5, then restart scanning.
      for (int i = 0; i < 20 && !(ma.busy && ma.sel == 5); i++)
         drive(1'b0, 1'b1, rnd64(), 8'($urandom), 8'($urandom));
      drive(1'b1, 1'b1, rnd64(), 8'($urandom), 8'($urandom));
      repeat (40) drive(1'b0, 1'b1, rnd64(), 8'($urandom), 8'($urandom));

      // Random enable, rare resets, cpuOutput changing every cycle.
      for (int i = 0; i < 800; i++)
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), rnd64(),
               8'($urandom), 8'($urandom));

      repeat (3) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
